// File: rtl/imem_loader.sv
// imem_loader: packs a framed byte stream (MAGIC, LEN_LO, LEN_HI, data) into 32-bit imem writes and holds the core in reset while loading.
// Latency: each word is written the cycle after its 4th byte arrives, and status settles one cycle after the frame ends. Build option LOADER_CHECKSUM_EN adds a trailing checksum byte.
// Backpressure: none; in_ready is always high, so a byte can be taken every cycle.
module imem_loader #(
   parameter int          FW_LENGTH = 8,
   parameter logic [31:0] BASE_ADDR = 32'h0,
   parameter logic [7:0]  MAGIC     = 8'hA5
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clear,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        cpu_rst_n,
   output logic        busy,
   output logic        done,
   output logic        error
);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_t;

   localparam logic [31:0] MAX_LEN = 32'(FW_LENGTH);
`ifdef LOADER_CHECKSUM_EN
   localparam state_t S_AFTER_DATA = S_CSUM;
`else
   localparam state_t S_AFTER_DATA = S_DONE;
`endif

   state_t      state, state_nxt;
   logic [7:0]  len_lo;
   logic [15:0] len;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] asm_q;

   logic        wr_en_nxt, cpu_rst_n_nxt, busy_nxt, done_nxt, error_nxt;
   logic [31:0] wr_addr_nxt, wr_data_nxt;

   logic        acc, start, word_done;
   logic [15:0] len_w;

   assign in_ready  = 1'b1;
   assign acc       = in_valid & in_ready;
   assign len_w     = {in_data, len_lo};
   assign start     = acc && (in_data == MAGIC) && (state == S_IDLE || state == S_DONE);
   assign word_done = acc && (state == S_DATA) && (byte_idx == 2'd3);

`ifdef LOADER_CHECKSUM_EN
   logic [7:0] sum_q;
   logic       csum_ok;
   assign csum_ok = (sum_q + in_data) == 8'h00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         sum_q <= 8'h00;
      else if (!clear && acc && state == S_LEN_HI)
         sum_q <= 8'h00;
      else if (!clear && acc && state == S_DATA)
         sum_q <= sum_q + in_data;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (clear) begin
         state_nxt = S_IDLE;
      end else if (acc) begin
         case (state)
            S_IDLE, S_DONE: if (in_data == MAGIC) state_nxt = S_LEN_LO;
            S_LEN_LO:       state_nxt = S_LEN_HI;
            S_LEN_HI: begin
               if ({16'h0, len_w} > MAX_LEN) state_nxt = S_ERR;
               else if (len_w == 16'h0)      state_nxt = S_AFTER_DATA;
               else                          state_nxt = S_DATA;
            end
            S_DATA: if (byte_idx == 2'd3 && word_idx == len - 16'd1) state_nxt = S_AFTER_DATA;
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: state_nxt = csum_ok ? S_DONE : S_ERR;
`endif
            default: ;
         endcase
      end
   end

   // busy doubles as the "first cycle in DONE" marker, so completion status lands one cycle after entry.
   always_comb begin
      wr_en_nxt     = 1'b0;
      wr_addr_nxt   = wr_addr;
      wr_data_nxt   = wr_data;
      cpu_rst_n_nxt = cpu_rst_n;
      busy_nxt      = busy;
      done_nxt      = done;
      error_nxt     = error;
      if (clear) begin
         busy_nxt  = 1'b0;
         done_nxt  = 1'b0;
         error_nxt = 1'b0;
      end else begin
         if (start) begin
            busy_nxt      = 1'b1;
            cpu_rst_n_nxt = 1'b0;
            done_nxt      = 1'b0;
            error_nxt     = 1'b0;
         end else if (state_nxt == S_ERR && state != S_ERR) begin
            busy_nxt  = 1'b0;
            error_nxt = 1'b1;
         end else if (state == S_DONE && busy) begin
            busy_nxt      = 1'b0;
            done_nxt      = 1'b1;
            cpu_rst_n_nxt = 1'b1;
         end
         if (word_done) begin
            wr_en_nxt   = 1'b1;
            wr_addr_nxt = BASE_ADDR + {14'd0, word_idx, 2'b00};
            wr_data_nxt = {in_data, asm_q};
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_en     <= 1'b0;
         wr_addr   <= BASE_ADDR;
         wr_data   <= 32'h0;
         cpu_rst_n <= 1'b1;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         wr_en     <= wr_en_nxt;
         wr_addr   <= wr_addr_nxt;
         wr_data   <= wr_data_nxt;
         cpu_rst_n <= cpu_rst_n_nxt;
         busy      <= busy_nxt;
         done      <= done_nxt;
         error     <= error_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_lo   <= 8'h0;
         len      <= 16'h0;
         word_idx <= 16'h0;
         byte_idx <= 2'd0;
         asm_q    <= 24'h0;
      end else if (!clear && acc) begin
         case (state)
            S_LEN_LO: len_lo <= in_data;
            S_LEN_HI: begin
               len      <= len_w;
               word_idx <= 16'h0;
               byte_idx <= 2'd0;
            end
            S_DATA: begin
               asm_q    <= {in_data, asm_q[23:8]};
               byte_idx <= byte_idx + 2'd1;
               if (byte_idx == 2'd3) word_idx <= word_idx + 16'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed frames, expected imem writes queued and checked by a wr_en monitor.
module tb_imem_loader;

   logic        clk = 1'b0;
   logic        rst_n, clear, in_valid, in_ready;
   logic [7:0]  in_data;
   logic        wr_en, cpu_rst_n, busy, done, error;
   logic [31:0] wr_addr, wr_data;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   wr_t        exp_q[$];
   wr_t        cur;
   logic [7:0] fq[$];
   int         checks = 0;
   int         errors = 0;

   imem_loader dut (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .cpu_rst_n(cpu_rst_n), .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_q();
      for (int i = 0; i < fq.size(); i++) begin
         in_valid = 1'b1;
         in_data  = fq[i];
         tick();
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
      exp_q.push_back('{addr: a, data: d});
   endtask

   always @(negedge clk) begin
      if (rst_n && wr_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr %h data %h expected no write", wr_addr, wr_data);
         end else begin
            cur = exp_q.pop_front();
            chk("wr_addr", wr_addr, cur.addr);
            chk("wr_data", wr_data, cur.data);
         end
      end
   end

   initial begin
      rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
      chk("rst_wr_addr", wr_addr, 32'h0);
      chk("rst_wr_data", wr_data, 32'h0);
      chk("rst_cpu_rst_n", {31'd0, cpu_rst_n}, 32'd1);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      @(posedge clk); #1; rst_n = 1'b1;
      tick();

      // Two-word program, bytes back to back.
      expect_wr(32'h0, 32'h00000013);
      expect_wr(32'h4, 32'h00100093);
      fq = '{8'hA5};
      send_q();
      chk("f1_busy_after_magic", {31'd0, busy}, 32'd1);
      chk("f1_cpu_rst_after_magic", {31'd0, cpu_rst_n}, 32'd0);
      fq = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      fq.push_back(8'h4A);
`endif
      send_q();
      chk("f1_cpu_rst_at_last_write", {31'd0, cpu_rst_n}, 32'd0);
      tick();
      chk("f1_done", {31'd0, done}, 32'd1);
      chk("f1_busy", {31'd0, busy}, 32'd0);
      chk("f1_cpu_rst_released", {31'd0, cpu_rst_n}, 32'd1);
      chk("f1_error", {31'd0, error}, 32'd0);

      // Garbage ahead of the frame is dropped.
      fq = '{8'h00, 8'hFF};
      send_q();
      chk("f2_garbage_busy", {31'd0, busy}, 32'd0);
      chk("f2_garbage_done_kept", {31'd0, done}, 32'd1);
      expect_wr(32'h0, 32'h12345678);
      fq = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
`ifdef LOADER_CHECKSUM_EN
      fq.push_back(8'hEC);
`endif
      send_q();
      tick();
      chk("f2_done", {31'd0, done}, 32'd1);

      // Oversized length is rejected and latches until clear.
      fq = '{8'hA5, 8'h09, 8'h00};
      send_q();
      tick();
      chk("f3_error", {31'd0, error}, 32'd1);
      chk("f3_busy", {31'd0, busy}, 32'd0);
      chk("f3_done", {31'd0, done}, 32'd0);
      chk("f3_cpu_rst_held", {31'd0, cpu_rst_n}, 32'd0);
      fq = '{8'hA5, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
      send_q();
      tick();
      chk("f3_magic_ignored_error", {31'd0, error}, 32'd1);
      chk("f3_magic_ignored_busy", {31'd0, busy}, 32'd0);
      pulse_clear();
      chk("f3_clear_error", {31'd0, error}, 32'd0);
      chk("f3_clear_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
      expect_wr(32'h0, 32'hDEADBEEF);
      fq = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
`ifdef LOADER_CHECKSUM_EN
      fq.push_back(8'hC8);
`endif
      send_q();
      tick();
      chk("f3_reload_done", {31'd0, done}, 32'd1);
      chk("f3_reload_cpu_rst", {31'd0, cpu_rst_n}, 32'd1);

      // Abort mid-frame: only the complete word lands.
      expect_wr(32'h0, 32'hCAFEF00D);
      fq = '{8'hA5, 8'h03, 8'h00, 8'h0D, 8'hF0, 8'hFE, 8'hCA, 8'h99};
      send_q();
      pulse_clear();
      chk("f4_busy", {31'd0, busy}, 32'd0);
      chk("f4_done", {31'd0, done}, 32'd0);
      chk("f4_error", {31'd0, error}, 32'd0);
      chk("f4_cpu_rst_held", {31'd0, cpu_rst_n}, 32'd0);
      fq = '{8'h55, 8'h66};
      send_q();
      tick();
      chk("f4_idle_no_frame", {31'd0, busy}, 32'd0);

      // Zero-length frame.
      fq = '{8'hA5, 8'h00, 8'h00};
`ifdef LOADER_CHECKSUM_EN
      fq.push_back(8'h00);
`endif
      send_q();
      chk("f5_cpu_rst_low", {31'd0, cpu_rst_n}, 32'd0);
      tick();
      chk("f5_done", {31'd0, done}, 32'd1);
      chk("f5_cpu_rst", {31'd0, cpu_rst_n}, 32'd1);

`ifdef LOADER_CHECKSUM_EN
      expect_wr(32'h0, 32'h04030201);
      fq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF6};
      send_q();
      tick();
      chk("cs_good_done", {31'd0, done}, 32'd1);
      chk("cs_good_error", {31'd0, error}, 32'd0);
      expect_wr(32'h0, 32'h04030201);
      fq = '{8'hA5, 8'h01, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'hF7};
      send_q();
      tick();
      chk("cs_bad_error", {31'd0, error}, 32'd1);
      chk("cs_bad_done", {31'd0, done}, 32'd0);
      chk("cs_bad_cpu_rst", {31'd0, cpu_rst_n}, 32'd0);
`endif

      repeat (3) tick();
      chk("pending_writes", exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
